spi_cmd_tx: RTL and testbench
=============================

SPI_CMD_TX -- requirements
Module: spi_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period, legal range 2..255.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous active-high reset.
- cmd_send  in  1  one-cycle pulse: start transmitting a command region.
- mem.region_begin  in  4  first buffer word index, sampled on cmd_send.
- mem.region_end  in  4  last buffer word index, sampled on cmd_send.
- mem.ptr  out  4  word index requested.
- mem.r_en  out  1  read request; held until mem.done.
- mem.done  in  1  one-cycle read acknowledge; data valid the same cycle.
- mem.data_load  in  32  read data.
- cmd_done  out  1  one-cycle pulse: region fully shifted out.
- busy  out  1  high whenever state is not IDLE.
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock, mode 0 (idle low).
- spi_mosi  out  1  serial data, MSB first.
REQ-003 SHALL use mem as a modport of mem_handle: region_begin, region_end, done and data_load are inputs; ptr and r_en are outputs.

Function
REQ-004 SHALL implement the FSM IDLE -> FETCH -> SHIFT -> (FETCH | DONE) -> IDLE.
REQ-005 IDLE: on cmd_send, SHALL latch region_begin and region_end, set ptr=region_begin and r_en=1 on the next edge, then enter FETCH.
REQ-006 SHALL ignore cmd_send in every state except IDLE; no queuing.
REQ-007 FETCH: in the cycle where r_en && done, SHALL load data_load into a 32-bit shift register, clear r_en, and drive cs_n=0 and mosi=data_load[31] on the next edge, then enter SHIFT.
REQ-008 SHALL hold r_en high indefinitely while done is low; done with r_en low SHALL be ignored.
REQ-009 SHIFT: a divider SHALL toggle sclk every CLK_DIV clk cycles, starting from sclk=0.
REQ-010 On each sclk falling toggle, SHALL shift the next bit onto mosi; mosi SHALL be stable through each rising edge.
REQ-011 SHALL emit exactly 32 rising edges per word; after the 32nd falling edge, sclk SHALL remain 0.
REQ-012 End of word, ptr != end: SHALL set ptr=ptr+1 (mod 16) and r_en=1, then enter FETCH with cs_n held low.
REQ-013 End of word, ptr == end: SHALL enter DONE.
REQ-014 Region length SHALL be ((end-begin) mod 16)+1 words; begin=end sends 1 word; begin>end wraps through 15 to 0.
REQ-015 DONE: SHALL set cs_n=1 and pulse cmd_done high for exactly one cycle, then return to IDLE.
REQ-016 In IDLE: cs_n=1, sclk=0, mosi=0, r_en=0.
REQ-017 Word shift time SHALL be 64*CLK_DIV clk cycles; fetch gap SHALL be mem latency plus 1 cycle, with sclk low.

Reset
REQ-018 On rst high at a clk edge, SHALL return to IDLE with outputs reset as follows:
- spi_cs_n=1; spi_sclk=0; spi_mosi=0.
- mem.r_en=0; mem.ptr=0.
- cmd_done=0; busy=0.
- divider, bit counter and shift register = 0.
REQ-019 Reset mid-transfer SHALL abort without a cmd_done pulse; the next cmd_send SHALL start cleanly.

Structure
REQ-020 Package spi_pkg SHALL hold WORD_W=32, PTR_W=4 and the FSM state enum, shared with the SPI receive stage.
REQ-021 SHALL instantiate sub-module spi_sclk_gen (parameter CLK_DIV; inputs clk, rst, en; outputs sclk, rise, fall strobes), one per block.

Verification
REQ-022 Single word: begin=3, end=3, buffer[3]=32'hA5C3_0F81, CLK_DIV=2 -> one cs_n low window, 32 sclk rising edges, mosi samples MSB-first = A5C30F81, one cmd_done pulse.
REQ-023 Multi-word: begin=0, end=2, words 11111111/22222222/33333333 -> 96 rising edges, cs_n low throughout, ptr sequence 0,1,2.
REQ-024 Wrap: begin=14, end=1 -> ptr sequence 14,15,0,1; 128 rising edges.
REQ-025 Slow memory: done delayed 5 cycles on each read -> r_en held for all 5 cycles, sclk low during gaps, data intact.
REQ-026 Busy/reset: cmd_send during SHIFT is ignored; rst asserted at bit 10 of word 0 -> next cycle cs_n=1, sclk=0, r_en=0, no cmd_done; a new cmd_send then sends the full region correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants and the command-engine state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   WORD_W   - bits per buffer word shifted out on MOSI
//   PTR_W    - width of the buffer word index
//   BITCNT_W - width of a counter that must reach WORD_W inclusive
//   state_e  - command engine FSM states, also used by the SPI receive stage
package spi_pkg;

  localparam int WORD_W   = 32;
  localparam int PTR_W    = 4;
  localparam int BITCNT_W = $clog2(WORD_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_cmd_tx_if.sv
// Buffer-memory handle between a command engine and the word buffer.
// Latency: n/a (wires only).
// Backpressure: requester holds r_en until the buffer answers with a done pulse.
//
// Signals:
//   region_begin / region_end - first/last word index of the region to send
//   ptr / r_en                - word index requested and read request level
//   done / data_load          - one-cycle read acknowledge with its data
// Modports:
//   master - the command engine (issues ptr/r_en)
//   slave  - the buffer (answers with done/data_load, supplies region bounds)
interface mem_handle;
  import spi_pkg::*;

  logic [PTR_W-1:0]  region_begin;
  logic [PTR_W-1:0]  region_end;
  logic [PTR_W-1:0]  ptr;
  logic              r_en;
  logic              done;
  logic [WORD_W-1:0] data_load;

  modport master (
    input  region_begin,
    input  region_end,
    input  done,
    input  data_load,
    output ptr,
    output r_en
  );

  modport slave (
    output region_begin,
    output region_end,
    output done,
    output data_load,
    input  ptr,
    input  r_en
  );

endinterface

// File: rtl/spi_cmd_tx_sclk_gen.sv
// SPI mode-0 clock divider: sclk toggles every CLK_DIV clk cycles while enabled.
// Latency: first rising toggle CLK_DIV cycles after en rises; strobes fire in the toggling cycle.
// Backpressure: none; dropping en returns sclk to 0 and restarts the divider.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   en        - run the divider; low forces sclk=0 and count=0
//   sclk      - registered SPI clock, idles low
//   rise/fall - single-cycle strobes, high in the cycle whose edge toggles sclk
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       tick;

  always_comb begin
    tick   = en && (cnt_q == DIV_LAST);
    rise   = tick && !sclk_q;
    fall   = tick && sclk_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_cmd_tx.sv
// SPI command transmitter: streams a wrap-around region of buffer words MSB-first.
// Latency: cs_n falls one cycle after the first read ack; each word takes 64*CLK_DIV cycles.
// Backpressure: r_en held indefinitely until mem.done; sclk parked low while waiting.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   cmd_send   - one-cycle start pulse, honoured only while idle
//   mem        - buffer handle (region bounds in, ptr/r_en out, done/data_load in)
//   cmd_done   - one-cycle pulse after the last word of the region is shifted out
//   busy       - engine is not idle
//   spi_cs_n, spi_sclk, spi_mosi - SPI mode-0 master outputs
module spi_cmd_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_send,
  mem_handle.master  mem,
  output logic       cmd_done,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi
);

  localparam logic [BITCNT_W-1:0] BITS_PER_WORD = BITCNT_W'(WORD_W);
  localparam logic [PTR_W-1:0]    PTR_STEP      = PTR_W'(1);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    end_q, end_d;
  logic                r_en_q, r_en_d;
  logic                cs_n_q, cs_n_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;

  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall;

  // Divider only runs in SHIFT; leaving SHIFT resets it so every word
  // starts with a full low half-period.
  assign sclk_en = (state_q == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sclk_en),
    .sclk (spi_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    end_d    = end_q;
    r_en_d   = r_en_q;
    cs_n_d   = cs_n_q;
    done_d   = 1'b0;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_send) begin
          ptr_d   = mem.region_begin;
          end_d   = mem.region_end;
          r_en_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // The MSB reaches MOSI together with cs_n falling, a full
        // half-period ahead of the first rising sclk.
        if (r_en_q && mem.done) begin
          shreg_d  = mem.data_load;
          bitcnt_d = '0;
          r_en_d   = 1'b0;
          cs_n_d   = 1'b0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // bitcnt counts bits already sampled by the slave (rising edges);
        // the falling edge after the last rise closes the word.
        if (sclk_rise) begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
        if (sclk_fall) begin
          if (bitcnt_q == BITS_PER_WORD) begin
            bitcnt_d = '0;
            if (ptr_q == end_q) begin
              cs_n_d  = 1'b1;
              done_d  = 1'b1;
              shreg_d = '0;
              state_d = ST_DONE;
            end else begin
              // Index wraps 15 -> 0 naturally in PTR_W bits.
              ptr_d   = ptr_q + PTR_STEP;
              r_en_d  = 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      end_q    <= '0;
      r_en_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      end_q    <= end_d;
      r_en_q   <= r_en_d;
      cs_n_q   <= cs_n_d;
      done_q   <= done_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // MOSI is the top of the shift register, which is zero whenever idle.
  assign spi_mosi = shreg_q[WORD_W-1];
  assign spi_cs_n = cs_n_q;
  assign cmd_done = done_q;
  assign busy     = (state_q != ST_IDLE);
  assign mem.ptr  = ptr_q;
  assign mem.r_en = r_en_q;

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Directed bench for spi_cmd_tx: buffer responder with programmable latency,
// SPI line monitor, and hand-computed expectations per region.
module tb_spi_cmd_tx;
  import spi_pkg::*;

  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic rst;
  logic cmd_send;
  logic cmd_done, busy, spi_cs_n, spi_sclk, spi_mosi;

  mem_handle mem();

  spi_cmd_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_send (cmd_send),
    .mem      (mem),
    .cmd_done (cmd_done),
    .busy     (busy),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- buffer responder ----------------
  logic [31:0] membuf [16];
  int lat  = 1;
  int rcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mem.done = 1'b0;
      rcnt = 0;
    end else if (mem.r_en && !mem.done) begin
      rcnt++;
      if (rcnt >= lat) begin
        mem.done      = 1'b1;
        mem.data_load = membuf[mem.ptr];
        rcnt = 0;
      end
    end else begin
      mem.done = 1'b0;
    end
  end

  // ---------------- SPI / handshake monitor ----------------
  int rises = 0, cs_win = 0, done_pulse = 0, done_cyc = 0;
  int mosi_err = 0, cs_err = 0, gap_err = 0, renrun = 0, rxn = 0;
  logic [31:0] rx = '0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0, prev_ren = 1'b0, prev_mosi = 1'b0;
  logic [31:0] words_q[$];
  int ptrs_q[$];
  int runs_q[$];

  always @(negedge clk) begin
    if (mem.r_en) renrun++;
    else if (renrun != 0) begin runs_q.push_back(renrun); renrun = 0; end
    if (mem.r_en && !prev_ren) ptrs_q.push_back(int'(mem.ptr));
    if (mem.r_en && spi_sclk) gap_err++;
    if (spi_sclk && !prev_sclk) begin
      rises++;
      if (spi_mosi !== prev_mosi) mosi_err++;
      if (spi_cs_n) cs_err++;
      rx = {rx[30:0], spi_mosi};
      rxn++;
      if (rxn == 32) begin words_q.push_back(rx); rxn = 0; end
    end
    if (spi_cs_n) rxn = 0;
    if (!spi_cs_n && prev_cs) cs_win++;
    if (cmd_done) done_cyc++;
    if (cmd_done && !prev_done) done_pulse++;
    prev_sclk = spi_sclk; prev_cs = spi_cs_n; prev_done = cmd_done;
    prev_ren = mem.r_en; prev_mosi = spi_mosi;
  end

  // ---------------- stimulus helpers ----------------
  int s_rises, s_win, s_dp, s_dc, s_words, s_ptrs, s_runs, s_gap, s_mosi, s_cserr;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic snap();
    s_rises = rises; s_win = cs_win; s_dp = done_pulse; s_dc = done_cyc;
    s_words = words_q.size(); s_ptrs = ptrs_q.size(); s_runs = runs_q.size();
    s_gap = gap_err; s_mosi = mosi_err; s_cserr = cs_err;
  endtask

  task automatic start_cmd(input logic [3:0] b, input logic [3:0] e);
    mem.region_begin = b;
    mem.region_end   = e;
    cmd_send = 1'b1;
    step(1);
    cmd_send = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] b, input logic [3:0] e);
    bit ok;
    snap();
    start_cmd(b, e);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (done_pulse > s_dp) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cmd_done_timeout", 32'd0, 32'd1);
    step(3);
  endtask

  task automatic wait_rises(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rises - s_rises >= n) begin ok = 1'b1; break; end
      step(1);
    end
    if (!ok) chk("rise_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_region(input string t, input int nw, input logic [3:0] b, input int l);
    logic [3:0] p;
    chk({t, "_rises"}, 32'(rises - s_rises), 32'(32 * nw));
    chk({t, "_cs_windows"}, 32'(cs_win - s_win), 32'd1);
    chk({t, "_done_pulses"}, 32'(done_pulse - s_dp), 32'd1);
    chk({t, "_done_cycles"}, 32'(done_cyc - s_dc), 32'd1);
    chk({t, "_word_count"}, 32'(words_q.size() - s_words), 32'(nw));
    chk({t, "_fetch_count"}, 32'(ptrs_q.size() - s_ptrs), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      p = b + 4'(k);
      chk($sformatf("%s_word%0d", t, k), words_q[s_words + k], membuf[p]);
      chk($sformatf("%s_ptr%0d", t, k), 32'(ptrs_q[s_ptrs + k]), 32'(p));
      chk($sformatf("%s_ren_run%0d", t, k), 32'(runs_q[s_runs + k]), 32'(l));
    end
    chk({t, "_mosi_unstable"}, 32'(mosi_err - s_mosi), 32'd0);
    chk({t, "_rise_cs_high"}, 32'(cs_err - s_cserr), 32'd0);
    chk({t, "_sclk_in_gap"}, 32'(gap_err - s_gap), 32'd0);
    chk({t, "_busy_after"}, 32'(busy), 32'd0);
    chk({t, "_cs_n_after"}, 32'(spi_cs_n), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    cmd_send = 1'b0;
    mem.region_begin = '0;
    mem.region_end = '0;
    for (int i = 0; i < 16; i++) membuf[i] = 32'h0;
    membuf[3]  = 32'hA5C3_0F81;
    membuf[0]  = 32'h1111_1111;
    membuf[1]  = 32'h2222_2222;
    membuf[2]  = 32'h3333_3333;
    membuf[14] = 32'hDEAD_BEEF;
    membuf[15] = 32'h0123_4567;
    membuf[5]  = 32'h8000_0001;
    membuf[6]  = 32'h7FFF_FFFE;

    step(3);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_r_en", 32'(mem.r_en), 32'd0);
    chk("rst_ptr", 32'(mem.ptr), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(2);

    lat = 1;
    run_cmd(4'd3, 4'd3);
    chk_region("single", 1, 4'd3, 1);

    run_cmd(4'd0, 4'd2);
    chk_region("multi", 3, 4'd0, 1);

    run_cmd(4'd14, 4'd1);
    chk_region("wrap", 4, 4'd14, 1);

    lat = 5;
    run_cmd(4'd5, 4'd6);
    chk_region("slow", 2, 4'd5, 5);
    lat = 1;

    // Start a region, poke cmd_send mid-word, then reset at bit 10.
    snap();
    start_cmd(4'd0, 4'd2);
    wait_rises(3);
    start_cmd(4'd9, 4'd9);
    step(2);
    chk("ignored_busy", 32'(busy), 32'd1);
    chk("ignored_ptr", 32'(mem.ptr), 32'd0);
    wait_rises(10);
    rst = 1'b1;
    step(1);
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_r_en", 32'(mem.r_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(20);
    chk("abort_no_done", 32'(done_pulse - s_dp), 32'd0);
    chk("abort_one_fetch", 32'(ptrs_q.size() - s_ptrs), 32'd1);

    run_cmd(4'd0, 4'd2);
    chk_region("restart", 3, 4'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
